toy_cpu_gen: RTL

Parametrised successor to the 8-bit toy CPU core, with a built-in narrow-bus instruction fetch.
- Assembles fixed-width instruction words from IN_W-bit chunks delivered over a valid/ready handshake, then executes them on a register file of configurable width and depth.
- Adds zero/carry flags, carry-chained add, compare, and a conditional skip.
- The output register drives the chip output pins.

---
 rtl/toy_cpu_gen.sv | 134 +++++++++++++
 1 files changed

// File: rtl/toy_cpu_gen.sv
// Parametrised toy CPU: assembles instruction words from narrow in_data chunks, then executes one per EXEC cycle.
// Results land on the edge that ends EXEC; in_ready drops only during EXEC.
module toy_cpu_gen #(
    parameter int DATA_W = 8,
    parameter int RA_W   = 3,
    parameter int IN_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] out,
    output logic              flag_z,
    output logic              flag_c,
    output logic              retired
);
    localparam int INSTR_W = 4 + 2*RA_W + DATA_W;
    localparam int NCHUNK  = (INSTR_W + IN_W - 1) / IN_W;
    localparam int CNT_W   = $clog2(NCHUNK + 1);
    localparam int NREGS   = 2**RA_W;

    localparam logic [3:0] OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_AND = 4'h4,
                           OP_OR  = 4'h5, OP_XOR = 4'h6, OP_SHL = 4'h7, OP_SHR = 4'h8,
                           OP_ADC = 4'h9, OP_OUT = 4'hA, OP_SKZ = 4'hB, OP_CMP = 4'hC;

    typedef enum logic {FETCH, EXEC} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [INSTR_W-1:0] word;
    logic [DATA_W-1:0]  regs [NREGS];
    logic               skip_pending;
    logic               accept;
    logic               last_chunk;

    logic [3:0]         op;
    logic [RA_W-1:0]    dest, a_idx, b_idx;
    logic [DATA_W-1:0]  imm, va, vb;
    logic [DATA_W:0]    res;
    logic               wr_en, flag_en;

    assign last_chunk = (cnt == CNT_W'(NCHUNK - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        retired   = 1'b0;
        case (state)
            FETCH: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && last_chunk) state_nxt = EXEC;
            end
            EXEC: begin
                retired   = !skip_pending;
                state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // New chunk enters at the LSB end; anything above INSTR_W (chunk-0 padding) falls off the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            word <= '0;
        end else if (accept) begin
            word <= INSTR_W'({word, in_data});
            cnt  <= last_chunk ? '0 : cnt + 1'b1;
        end
    end

    assign op    = word[INSTR_W-1 -: 4];
    assign dest  = word[INSTR_W-5 -: RA_W];
    assign a_idx = word[DATA_W+RA_W-1 -: RA_W];
    assign imm   = word[DATA_W-1:0];
    assign b_idx = imm[RA_W-1:0];

    // res carries the carry/borrow in its top bit and the data result below it.
    always_comb begin
        va      = regs[a_idx];
        vb      = regs[b_idx];
        res     = '0;
        wr_en   = 1'b0;
        flag_en = 1'b0;
        case (op)
            OP_LDI: begin res = {1'b0, imm};                 wr_en = 1'b1; end
            OP_ADD: begin res = {1'b0, va} + {1'b0, vb};     wr_en = 1'b1; flag_en = 1'b1; end
            OP_SUB: begin res = {1'b0, va} - {1'b0, vb};     wr_en = 1'b1; flag_en = 1'b1; end
            OP_AND: begin res = {1'b0, va & vb};             wr_en = 1'b1; flag_en = 1'b1; end
            OP_OR:  begin res = {1'b0, va | vb};             wr_en = 1'b1; flag_en = 1'b1; end
            OP_XOR: begin res = {1'b0, va ^ vb};             wr_en = 1'b1; flag_en = 1'b1; end
            OP_SHL: begin res = {va, 1'b0};                  wr_en = 1'b1; flag_en = 1'b1; end
            OP_SHR: begin res = {va[0], 1'b0, va[DATA_W-1:1]}; wr_en = 1'b1; flag_en = 1'b1; end
            OP_ADC: begin
                res     = {1'b0, va} + {1'b0, vb} + {{DATA_W{1'b0}}, flag_c};
                wr_en   = 1'b1;
                flag_en = 1'b1;
            end
            OP_CMP: begin res = {1'b0, va} - {1'b0, vb};     flag_en = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out          <= '0;
            flag_z       <= 1'b0;
            flag_c       <= 1'b0;
            skip_pending <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (state == EXEC) begin
            if (skip_pending) begin
                skip_pending <= 1'b0;
            end else begin
                if (wr_en) regs[dest] <= res[DATA_W-1:0];
                if (flag_en) begin
                    flag_z <= (res[DATA_W-1:0] == '0);
                    flag_c <= res[DATA_W];
                end
                if (op == OP_OUT) out <= va;
                if (op == OP_SKZ) skip_pending <= flag_z;
            end
        end
    end

endmodule
